// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line plus received-byte outputs of the UART receiver.
//   rx          : serial line, idle high (driven by the line side)
//   uart_byte   : last correctly framed byte
//   data_rdy    : one-cycle strobe when uart_byte updates
//   framing_err : one-cycle strobe when a stop bit is sampled low
// Modports: slave = receiver side, master = line driver / byte consumer.
interface uart_rx_if;
  logic       rx;
  logic [7:0] uart_byte;
  logic       data_rdy;
  logic       framing_err;

  modport master (
    output rx,
    input  uart_byte,
    input  data_rdy,
    input  framing_err
  );

  modport slave (
    input  rx,
    output uart_byte,
    output data_rdy,
    output framing_err
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 UART receiver, LSB first.
// Ports:
//   uart_sampling_clk : sole clock, rising edge
//   rst               : asynchronous active-high reset
//   bus (slave)       : rx in; uart_byte, data_rdy, framing_err out
// Parameters:
//   OVERSAMPLE : clock cycles per bit (even, >= 4)
//   DATA_BITS  : data bits per frame (1..8), upper uart_byte bits zero-filled
// Build option:
//   UART_RX_MAJORITY_EN : when defined, each sample point takes a 2-of-3 vote
//                         over rx_s at the sample edge and the two edges before.
//
// state   | meaning
// IDLE    | waiting for rx_s low (start edge)
// START   | counting to mid start bit, reject false starts
// DATA    | sampling data bits at mid bit
// STOP    | sampling stop bit at mid bit
// BREAK   | stop bit was low, wait for line to return high
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input logic       uart_sampling_clk,
  input logic       rst,
  uart_rx_if.slave  bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic sync1_q;
  logic rx_s_q;
  logic sample;

  always_ff @(posedge uart_sampling_clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= bus.rx;
      rx_s_q  <= sync1_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] is rx_s from one edge ago, hist_q[1] from two edges ago.
  logic [1:0] hist_q;

  always_ff @(posedge uart_sampling_clk or posedge rst) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s_q};
    end
  end

  assign sample = (rx_s_q & hist_q[0]) | (rx_s_q & hist_q[1]) |
                  (hist_q[0] & hist_q[1]);
`else
  assign sample = rx_s_q;
`endif

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   sr_q, sr_d;
  logic [7:0]             byte_q, byte_d;
  logic                   rdy_q, rdy_d;
  logic                   ferr_q, ferr_d;
  logic [DATA_BITS:0]     shifted;

  always_ff @(posedge uart_sampling_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sr_q    <= '0;
      byte_q  <= 8'h00;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      byte_q  <= byte_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sr_d    = sr_q;
    byte_d  = byte_q;
    rdy_d   = 1'b0;
    ferr_d  = 1'b0;
    // New bit enters at the MSB so the first received bit ends at the LSB.
    shifted = {sample, sr_q};

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          if (sample) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          sr_d  = shifted[DATA_BITS:1];
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (sample) begin
            // Leave at mid stop bit so the next start edge is caught in time.
            byte_d  = 8'(sr_q);
            rdy_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.uart_byte   = byte_q;
  assign bus.data_rdy    = rdy_q;
  assign bus.framing_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  localparam int OS       = 16;
  localparam int FRAME    = 10 * OS;
  localparam int STOP_OFS = 2 + OS / 2 + 9 * OS;  // 154 cycles after edge k

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_if bif();

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .uart_sampling_clk (clk),
    .rst               (rst),
    .bus               (bif)
  );

  typedef struct {
    bit          ferr;
    logic [7:0]  b;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          vectors = 0;
  int          errors = 0;
  logic [7:0]  last_good = 8'h00;
  logic [7:0]  maj_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: any output strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0 && (bif.data_rdy === 1'b1 || bif.framing_err === 1'b1)) begin
      chk("strobe_exclusive", {31'd0, bif.data_rdy & bif.framing_err}, 32'd0);
      if (sb_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_event: got rdy=%b ferr=%b byte=%h at cycle %0d, expected no event",
                 bif.data_rdy, bif.framing_err, bif.uart_byte, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("event_kind_ferr", {31'd0, bif.framing_err}, {31'd0, mon_e.ferr});
        chk("uart_byte", {24'd0, bif.uart_byte}, {24'd0, mon_e.b});
        chk("event_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Drives one frame cycle by cycle; must be called just after a falling edge.
  // glitch_t inverts rx for the single edge k+glitch_t; abort_t stops early.
  task automatic send_frame(input logic [7:0] b, input bit stop_val,
                            input logic [7:0] exp_b, input int glitch_t,
                            input int abort_t);
    int unsigned k;
    exp_t        e;
    logic        v;
    k = cyc + 1;
    if (abort_t < 0) begin
      e.ferr = !stop_val;
      e.b    = stop_val ? exp_b : last_good;
      e.cyc  = k + STOP_OFS;
      sb_q.push_back(e);
      if (stop_val) last_good = exp_b;
    end
    for (int t = 0; t < FRAME; t++) begin
      if (t == abort_t) return;
      if (t < OS)          v = 1'b0;
      else if (t < 9 * OS) v = b[t / OS - 1];
      else                 v = stop_val;
      if (t == glitch_t) v = ~v;
      bif.rx = v;
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    bif.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

`ifdef UART_RX_MAJORITY_EN
  initial maj_exp = 8'h81;
`else
  initial maj_exp = 8'h85;
`endif

  initial begin
    rst    = 1'b1;
    bif.rx = 1'b1;
    @(negedge clk);
    chk("reset_uart_byte", {24'd0, bif.uart_byte}, 32'h00);
    chk("reset_data_rdy", {31'd0, bif.data_rdy}, 32'd0);
    chk("reset_framing_err", {31'd0, bif.framing_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(5);

    // Single frame
    send_frame(8'hA5, 1'b1, 8'hA5, -1, -1);
    idle(20);

    // Back-to-back, no idle gap
    send_frame(8'hFF, 1'b1, 8'hFF, -1, -1);
    send_frame(8'hF0, 1'b1, 8'hF0, -1, -1);
    idle(20);

    // Glitch rejection, then a frame to show the FSM is back in IDLE
    bif.rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    send_frame(8'h12, 1'b1, 8'h12, -1, -1);
    idle(20);

    // Framing error, line held low, then released
    send_frame(8'h3C, 1'b0, 8'h3C, -1, -1);
    bif.rx = 1'b0;
    repeat (40) @(negedge clk);
    idle(20);
    send_frame(8'h66, 1'b1, 8'h66, -1, -1);
    idle(20);

    // Reset during data bit 3
    send_frame(8'h77, 1'b1, 8'h77, -1, 4 * OS + 6);
    rst = 1'b1;
    #1;
    chk("midreset_uart_byte", {24'd0, bif.uart_byte}, 32'h00);
    chk("midreset_data_rdy", {31'd0, bif.data_rdy}, 32'd0);
    chk("midreset_framing_err", {31'd0, bif.framing_err}, 32'd0);
    bif.rx = 1'b1;
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    last_good = 8'h00;
    idle(20);
    send_frame(8'h5A, 1'b1, 8'h5A, -1, -1);
    idle(20);

    // One-cycle glitch landing on the bit-2 sample edge (k+58 at the FSM)
    send_frame(8'h81, 1'b1, maj_exp, 3 * OS + 8, -1);
    idle(10);

    for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL missing_events: %0d expected strobes never seen, expected 0 outstanding",
               sb_q.size());
    end
    idle(50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
